rv_multicycle_ctrl: RTL
=======================

# rv_multicycle_ctrl

Control sequencer for the multi-cycle RV32I core. Decodes the latched instruction and steps the shared datapath through its phases: fetch, decode, execute, memory and writeback. It drives every datapath select and write enable, including the immediate-type select consumed by the immediate extender. It also owns the single shared memory port handshake and a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  instruction register contents (valid from DECODE onward)
- branch_taken  in  1  datapath comparator result for current B-type funct3
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (stores only)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  latch IR and old_pc
- pc_we  out  1  PC write enable
- pc_sel  out  1  0 = PC+4, 1 = ALU result
- imm_sel  out  3  immediate type to extender
- alu_src_a  out  2  0 = rs1, 1 = old_pc, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
- alu_op  out  2  0 = add, 1 = funct-decoded, 2 = compare
- reg_we  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = old_pc+4
- trap  out  1  illegal opcode seen; core halted
- instret  out  32  retired instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE is entered on reset. It lasts one cycle with all outputs 0, then goes to FETCH.
- FETCH
  - Outputs: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0, next state DECODE.
  - Otherwise: stay in FETCH.
- DECODE: reads opcode inst[6:2].
  - Legal opcodes are R, I-alu, load, store, branch, jal, jalr, lui and auipc. These go to EXEC.
  - Any other opcode, or inst[1:0]≠2'b11, goes to TRAP.
- EXEC: imm_sel is set per opcode. Datapath controls and next state:
  - R: src_a=rs1, src_b=rs2, alu_op=1; next WB.
  - I-alu: src_b=imm, alu_op=1; next WB.
  - load: add rs1+imm; next MEM.
  - store: add rs1+imm; next MEM.
  - lui: src_a=zero, src_b=imm; next WB.
  - auipc: src_a=old_pc, src_b=imm; next WB.
  - branch:
    - The datapath compares in the same cycle.
    - If branch_taken, ALU adds old_pc+imm and pc_we=1, pc_sel=1.
    - Next FETCH, retire.
  - jal: pc_we=1, pc_sel=1 with target old_pc+imm; next WB.
  - jalr: pc_we=1, pc_sel=1 with target rs1+imm; next WB.
  - The datapath clears the jalr target LSB.
- MEM
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=1 for store.
  - On mem_ready: store goes to FETCH (retire); load goes to WB.
  - Otherwise: stay in MEM.
- WB
  - Outputs: reg_we=1.
  - wb_sel: 1 for load, 2 for jal/jalr, 0 otherwise.
  - Next FETCH (retire).
- TRAP: trap=1, all enables 0. The block stays in TRAP until reset.
- instret increments by 1, wrapping at 2^32, on each retire transition.
- rd=x0 suppression belongs to the register file, not this block.

## Timing
- Reset values:
  - State IDLE.
  - instret=0.
  - All outputs 0. This holds immediately on rst_n low, which is asynchronous and may arrive mid-instruction or mid-request.
  - An outstanding memory request is dropped at reset.
  - mem_ready arriving during IDLE/reset is ignored.
- Minimum cycles per instruction, with mem_ready=1 on the first request cycle:
  - branch 3
  - store 4
  - R, I, lui, auipc, jal, jalr 4
  - load 5
- Each memory wait cycle adds 1 cycle.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel are held constant from request start until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
- Control outputs are combinational from state and the inst/mem_ready/branch_taken inputs; they take no registered delay.
- pc_we and ir_we are single-cycle pulses.

## Structure
- Shared package rv_ctrl_pkg holds:
  - state enum
  - opcode constants (5-bit inst[6:2])
  - imm_sel encoding: I=0, S=1, B=2, U=3, J=4, none=7
  - alu_src_a/b, alu_op and wb_sel encodings
- The package is shared with the immediate extender and the datapath.
- Natural sub-module: rv_opcode_decode, a combinational opcode class plus legality check, used in DECODE/EXEC.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready=1 → states IDLE, FETCH, DECODE, EXEC, WB; reg_we=1 only in WB; instret=1 after 5 cycles.
- lw x5,8(x1) (0x0080A283) with mem_ready delayed 2 cycles in MEM → mem_req held with mem_addr_sel=1 for 3 MEM cycles; WB wb_sel=1; total 7 cycles.
- beq (0x00208463): branch_taken=1 → EXEC pc_we=1, pc_sel=1, imm_sel=2. With branch_taken=0 → pc_we=0. Both cases retire in 3 cycles.
- sw x2,4(x1) (0x0020A223) → MEM mem_we=1, imm_sel=1, no WB, reg_we never asserted.
- Illegal word 0xFFFFFFFF → TRAP, trap=1 held for 100 cycles, instret unchanged; rst_n low then returns to IDLE.
- rst_n asserted mid-MEM with mem_req=1 → mem_req=0 in the same cycle, instret=0, restart at IDLE.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core.
// The immediate extender, the datapath and the control sequencer all import
// this package, so the select encodings below are the contract between them.
package rv_ctrl_pkg;

    // Sequencer phases; IDLE is the reset state, TRAP is terminal until reset.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9
    } op_class_e;

    // Major opcodes as seen in inst[6:2] (inst[1:0] must be 2'b11).
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // Immediate formats understood by the immediate extender.
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    // ALU operand A sources.
    localparam logic [1:0] SRCA_RS1    = 2'd0;
    localparam logic [1:0] SRCA_OLD_PC = 2'd1;
    localparam logic [1:0] SRCA_ZERO   = 2'd2;

    // ALU operand B sources.
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // ALU operation selects.
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_CMP   = 2'd2;

    // Register file writeback sources.
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    // Immediate format implied by an instruction class; R-type has none.
    function automatic logic [2:0] imm_sel_for(op_class_e cls);
        logic [2:0] sel;
        case (cls)
            CLS_I, CLS_LOAD, CLS_JALR: sel = IMM_I;
            CLS_STORE:                 sel = IMM_S;
            CLS_BRANCH:                sel = IMM_B;
            CLS_LUI, CLS_AUIPC:        sel = IMM_U;
            CLS_JAL:                   sel = IMM_J;
            default:                   sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational opcode classifier for the control sequencer.
// Maps the low seven instruction bits onto an instruction class and flags
// anything outside the supported RV32I subset as illegal.
module rv_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] inst_i,
    output logic [3:0] op_class_o,
    output logic       legal_o
);

    // Classify the major opcode; compressed/unknown encodings stay illegal.
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (inst_i[1:0] == 2'b11) begin
            case (inst_i[6:2])
                OPC_OP:     op_class_o = CLS_R;
                OPC_OP_IMM: op_class_o = CLS_I;
                OPC_LOAD:   op_class_o = CLS_LOAD;
                OPC_STORE:  op_class_o = CLS_STORE;
                OPC_BRANCH: op_class_o = CLS_BRANCH;
                OPC_JAL:    op_class_o = CLS_JAL;
                OPC_JALR:   op_class_o = CLS_JALR;
                OPC_LUI:    op_class_o = CLS_LUI;
                OPC_AUIPC:  op_class_o = CLS_AUIPC;
                default:    op_class_o = CLS_ILLEGAL;
            endcase
        end
    end

    assign legal_o = (op_class_o != CLS_ILLEGAL);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Control sequencer for the multi-cycle RV32I core.
// Walks the shared datapath through FETCH/DECODE/EXEC/MEM/WB, owns the single
// memory port handshake and keeps the retired-instruction counter. All control
// outputs are decoded combinationally from the current phase and the IR.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic [3:0]  op_class_raw;
    op_class_e   op_class;
    logic        op_legal;
    logic        retire;
    logic        unused_inst_bits;

    // Only the opcode field steers control; the rest of the IR feeds the datapath.
    assign unused_inst_bits = ^inst[31:7];

    rv_opcode_decode u_decode (
        .inst_i     (inst[6:0]),
        .op_class_o (op_class_raw),
        .legal_o    (op_legal)
    );

    assign op_class = op_class_e'(op_class_raw);
    assign instret  = instret_q;

    // Phase sequencing plus every datapath select/enable for the current phase.
    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        imm_sel      = 3'd0;
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        trap         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b0;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = 1'b0;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = op_legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                imm_sel = imm_sel_for(op_class);
                case (op_class)
                    CLS_R: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_RS2;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_I: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_ADD;
                        state_d   = ST_MEM;
                    end
                    CLS_LUI: begin
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                        state_d   = ST_WB;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = SRCA_OLD_PC;
                        alu_src_b = SRCB_IMM;
                        state_d   = ST_WB;
                    end
                    CLS_BRANCH: begin
                        // The comparator runs alongside; the ALU only builds the target when taken.
                        if (branch_taken) begin
                            alu_src_a = SRCA_OLD_PC;
                            alu_src_b = SRCB_IMM;
                            pc_we     = 1'b1;
                            pc_sel    = 1'b1;
                        end
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        alu_src_a = SRCA_OLD_PC;
                        alu_src_b = SRCB_IMM;
                        pc_we     = 1'b1;
                        pc_sel    = 1'b1;
                        state_d   = ST_WB;
                    end
                    CLS_JALR: begin
                        // Target LSB clearing is done in the datapath.
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        pc_we     = 1'b1;
                        pc_sel    = 1'b1;
                        state_d   = ST_WB;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_class == CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_we = 1'b1;
                if (op_class == CLS_LOAD) begin
                    wb_sel = WB_LOAD;
                end else if (op_class == CLS_JAL || op_class == CLS_JALR) begin
                    wb_sel = WB_LINK;
                end else begin
                    wb_sel = WB_ALU;
                end
                retire  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Phase register and retire counter; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule
